imm_ext_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage. Accepts a raw

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_decode.sv | 83 ++++++++
 rtl/imm_ext_pipe.sv | 134 +++++++++++++
 tb/tb_imm_ext_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select encoding
// and the set of datapath widths the pipeline supports.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_U     = 3'b001,
        IMM_S     = 3'b010,
        IMM_J     = 3'b011,
        IMM_LOAD  = 3'b100,
        IMM_CSRI  = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_B     = 3'b111
    } imm_sel_t;

    // Base encoding is always 32 bits, even on RV64.
    localparam int INSTR_W = 32;

    // The only datapath widths the extender knows how to fill.
    localparam int LEGAL_WIDTH_NARROW = 32;
    localparam int LEGAL_WIDTH_WIDE   = 64;

    function automatic bit width_ok(input int w);
        return (w == LEGAL_WIDTH_NARROW) || (w == LEGAL_WIDTH_WIDE);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format mux: slices the instruction fields for the
// selected format into a 32-bit value, then widens it to DATA_WIDTH either by
// sign fill (signed formats) or zero fill (CSR/shift formats).
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [INSTR_W-1:0]    instr,
    input  imm_sel_t              sel,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  err
);

    logic [31:0] low_bits;
    logic        sign_fill;
    logic        unused_opcode;

    // The opcode field never contributes to any immediate.
    assign unused_opcode = ^instr[6:0];

    // Field extraction per format; low_bits already carries the sign to bit 31.
    always_comb begin
        low_bits  = '0;
        sign_fill = 1'b0;
        err       = 1'b0;
        case (sel)
            IMM_I, IMM_LOAD: begin
                low_bits  = {{20{instr[31]}}, instr[31:20]};
                sign_fill = instr[31];
            end
            IMM_U: begin
                low_bits  = {instr[31:12], 12'b0};
                sign_fill = instr[31];
            end
            IMM_S: begin
                low_bits  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sign_fill = instr[31];
            end
            IMM_J: begin
                low_bits  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
                sign_fill = instr[31];
            end
            IMM_B: begin
                low_bits  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
                sign_fill = instr[31];
            end
            IMM_CSRI: begin
                low_bits = {27'b0, instr[19:15]};
            end
            IMM_SHAMT: begin
                if (DATA_WIDTH == LEGAL_WIDTH_WIDE) begin
                    low_bits = {26'b0, instr[25:20]};
                end else begin
                    // On a 32-bit datapath shamt[5] is reserved; flag it but
                    // still hand back the 5-bit amount.
                    low_bits = {27'b0, instr[24:20]};
                    err      = instr[25];
                end
            end
            default: begin
                low_bits = '0;
            end
        endcase
    end

    wire [DATA_WIDTH-1:0] ext_bits;

    assign ext_bits[31:0] = low_bits;

    // Upper bits replicate the fill bit; no iterations on a 32-bit datapath.
    genvar gi;
    generate
        for (gi = 32; gi < DATA_WIDTH; gi++) begin : g_fill
            assign ext_bits[gi] = sign_fill;
        end
    endgenerate

    assign imm = ext_bits;

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate generator for decode. Stage 1 holds the decoded
// immediate, PC and error flag; stage 2 adds the PC-relative target. A plain
// valid/ready pipeline with no skid buffer: each stage moves forward only
// when the slot ahead of it is empty or draining this cycle.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0]  in_pc,
    input  imm_sel_t               in_imm_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_imm,
    output logic [DATA_WIDTH-1:0]  out_target,
    output logic [DATA_WIDTH-1:0]  out_pc,
    output logic                   out_err
);

    generate
        if (!width_ok(DATA_WIDTH)) begin : g_bad_width
            $error("imm_ext_pipe: DATA_WIDTH must be 32 or 64");
        end
        if (INSTR_WIDTH != INSTR_W) begin : g_bad_instr
            $error("imm_ext_pipe: INSTR_WIDTH must be 32");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_err;

    imm_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr (in_instr),
        .sel   (in_imm_sel),
        .imm   (dec_imm),
        .err   (dec_err)
    );

    logic                  s1_valid_reg, s1_valid_next;
    logic [DATA_WIDTH-1:0] s1_imm_reg;
    logic [DATA_WIDTH-1:0] s1_pc_reg;
    logic                  s1_err_reg;

    logic                  s2_valid_reg, s2_valid_next;
    logic [DATA_WIDTH-1:0] s2_imm_reg;
    logic [DATA_WIDTH-1:0] s2_pc_reg;
    logic [DATA_WIDTH-1:0] s2_target_reg;
    logic                  s2_err_reg;

    logic s1_advance;
    logic s1_load;
    logic s2_load;

    // Handshake and occupancy: flush wins over everything and blocks new input,
    // but a consumer that takes the output in the flush cycle still gets it.
    always_comb begin
        s1_advance    = !s2_valid_reg || out_ready;
        in_ready      = !flush && (!s1_valid_reg || s1_advance);
        s1_load       = in_valid && in_ready;
        s2_load       = s1_valid_reg && s1_advance && !flush;
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        if (flush) begin
            s1_valid_next = 1'b0;
            s2_valid_next = 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_next = 1'b1;
            end else if (s2_load) begin
                s1_valid_next = 1'b0;
            end
            if (s2_load) begin
                s2_valid_next = 1'b1;
            end else if (s2_valid_reg && out_ready) begin
                s2_valid_next = 1'b0;
            end
        end
    end

    // Valid bits are the only control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
        end
    end

    // Stage 1 data captures the decoded entry only when it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_imm_reg <= '0;
            s1_pc_reg  <= '0;
            s1_err_reg <= 1'b0;
        end else if (s1_load) begin
            s1_imm_reg <= dec_imm;
            s1_pc_reg  <= in_pc;
            s1_err_reg <= dec_err;
        end
    end

    // Stage 2 data forms the target; holding while stalled keeps out_* stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_imm_reg    <= '0;
            s2_pc_reg     <= '0;
            s2_target_reg <= '0;
            s2_err_reg    <= 1'b0;
        end else if (s2_load) begin
            s2_imm_reg    <= s1_imm_reg;
            s2_pc_reg     <= s1_pc_reg;
            s2_target_reg <= s1_pc_reg + s1_imm_reg;
            s2_err_reg    <= s1_err_reg;
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_imm    = s2_imm_reg;
    assign out_pc     = s2_pc_reg;
    assign out_target = s2_target_reg;
    assign out_err    = s2_err_reg;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 32-bit and a 64-bit instance share stimulus.
// Directed table vectors, hand-written backpressure/flush/reset sequences and a
// randomized phase are all scored against a queue-based reference model.
module tb_imm_ext_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    imm_sel_t    in_imm_sel;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_out_imm, a_out_target, a_out_pc;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [63:0] b_out_imm, b_out_target, b_out_pc;

    imm_ext_pipe #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_imm_sel(in_imm_sel),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_target(a_out_target), .out_pc(a_out_pc),
        .out_err(a_out_err)
    );

    imm_ext_pipe #(.DATA_WIDTH(64), .INSTR_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_imm_sel(in_imm_sel),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_target(b_out_target), .out_pc(b_out_pc),
        .out_err(b_out_err)
    );

    typedef struct {
        logic [63:0] imm32, tgt32, pc32;
        logic        err32;
        logic [63:0] imm64, tgt64, pc64;
        logic        err64;
        int          acc_edge;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        imm_sel_t    sel;
        logic [63:0] pc;
        logic [63:0] imm32, tgt32;
        logic        err32;
        logic [63:0] imm64, tgt64;
        logic        err64;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   xfers    = 0;
    bit   accepted;
    exp_t cur;
    exp_t sb[$];
    vec_t vec[10];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endfunction

    // Reference: field values assembled with shifts/masks on signed 64-bit integers.
    function automatic void model(input logic [31:0] i, input imm_sel_t sel, input int dw,
                                  output logic [63:0] imm, output logic err);
        longint si, v, p0, p1, p2, p3;
        si  = longint'($signed(i));
        v   = 0;
        err = 1'b0;
        case (sel)
            IMM_I, IMM_LOAD: v = si >>> 20;
            IMM_U: begin
                p0 = si >>> 12;
                v  = p0 * 4096;
            end
            IMM_S: begin
                p0 = si >>> 25;
                p1 = longint'((i >> 7) & 32'h1F);
                v  = p0 * 32 + p1;
            end
            IMM_J: begin
                p0 = longint'((i >> 21) & 32'h3FF);
                p1 = longint'((i >> 20) & 32'h1);
                p2 = longint'((i >> 12) & 32'hFF);
                p3 = i[31] ? longint'(1 << 20) : 0;
                v  = p0 * 2 + p1 * 2048 + p2 * 4096 - p3;
            end
            IMM_B: begin
                p0 = longint'((i >> 8) & 32'hF);
                p1 = longint'((i >> 25) & 32'h3F);
                p2 = longint'((i >> 7) & 32'h1);
                p3 = i[31] ? 4096 : 0;
                v  = p0 * 2 + p1 * 32 + p2 * 2048 - p3;
            end
            IMM_CSRI: v = longint'((i >> 15) & 32'h1F);
            IMM_SHAMT: begin
                if (dw == 64) begin
                    v = longint'((i >> 20) & 32'h3F);
                end else begin
                    v   = longint'((i >> 20) & 32'h1F);
                    err = i[25];
                end
            end
            default: v = 0;
        endcase
        imm = (dw == 64) ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    endfunction

    function automatic void set_model();
        logic [63:0] imm;
        logic        err;
        model(in_instr, in_imm_sel, 32, imm, err);
        cur.imm32 = imm;
        cur.err32 = err;
        cur.pc32  = in_pc & 64'hFFFF_FFFF;
        cur.tgt32 = (cur.pc32 + imm) & 64'hFFFF_FFFF;
        model(in_instr, in_imm_sel, 64, imm, err);
        cur.imm64 = imm;
        cur.err64 = err;
        cur.pc64  = in_pc;
        cur.tgt64 = in_pc + imm;
    endfunction

    task automatic offer_random();
        in_instr   = $urandom;
        in_imm_sel = imm_sel_t'($urandom_range(0, 7));
        in_pc      = {$urandom, $urandom};
        set_model();
    endtask

    // One clock: check everything at the falling edge, update the scoreboard,
    // then step past the rising edge so the caller can drive the next cycle.
    task automatic tick();
        logic exp_ready, exp_valid;
        @(negedge clk);
        exp_ready = !flush && ((sb.size() < 2) || out_ready);
        exp_valid = (sb.size() > 0) && ((edge_cnt - sb[0].acc_edge) >= 2);
        chk("in_ready32", a_in_ready, exp_ready);
        chk("in_ready64", b_in_ready, exp_ready);
        chk("out_valid32", a_out_valid, exp_valid);
        chk("out_valid64", b_out_valid, exp_valid);
        if (exp_valid) begin
            chk("imm32", a_out_imm, sb[0].imm32);
            chk("target32", a_out_target, sb[0].tgt32);
            chk("pc32", a_out_pc, sb[0].pc32);
            chk("err32", a_out_err, sb[0].err32);
            chk("imm64", b_out_imm, sb[0].imm64);
            chk("target64", b_out_target, sb[0].tgt64);
            chk("pc64", b_out_pc, sb[0].pc64);
            chk("err64", b_out_err, sb[0].err64);
        end
        accepted = 1'b0;
        if (exp_valid && out_ready) begin
            xfers++;
            $display("XFER %0d imm32=%h tgt32=%h err32=%b imm64=%h tgt64=%h err64=%b",
                     xfers, a_out_imm, a_out_target, a_out_err, b_out_imm, b_out_target, b_out_err);
            void'(sb.pop_front());
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && exp_ready) begin
            cur.acc_edge = edge_cnt;
            sb.push_back(cur);
            accepted = 1'b1;
        end
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid32"}, a_out_valid, 0);
        chk({tag, "_imm32"}, a_out_imm, 0);
        chk({tag, "_target32"}, a_out_target, 0);
        chk({tag, "_pc32"}, a_out_pc, 0);
        chk({tag, "_err32"}, a_out_err, 0);
        chk({tag, "_valid64"}, b_out_valid, 0);
        chk({tag, "_imm64"}, b_out_imm, 0);
        chk({tag, "_target64"}, b_out_target, 0);
        chk({tag, "_pc64"}, b_out_pc, 0);
        chk({tag, "_err64"}, b_out_err, 0);
    endtask

    initial begin
        vec[0] = '{32'hFFF00093, IMM_I,     64'h100, 64'hFFFFFFFF, 64'hFF, 1'b0,
                   64'hFFFFFFFFFFFFFFFF, 64'hFF, 1'b0};
        vec[1] = '{32'h12345037, IMM_U,     64'h100, 64'h12345000, 64'h12345100, 1'b0,
                   64'h12345000, 64'h12345100, 1'b0};
        vec[2] = '{32'h80000037, IMM_U,     64'h0, 64'h80000000, 64'h80000000, 1'b0,
                   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
        vec[3] = '{32'hFFDFF06F, IMM_J,     64'h200, 64'hFFFFFFFC, 64'h1FC, 1'b0,
                   64'hFFFFFFFFFFFFFFFC, 64'h1FC, 1'b0};
        vec[4] = '{32'h00000463, IMM_B,     64'h300, 64'h8, 64'h308, 1'b0,
                   64'h8, 64'h308, 1'b0};
        vec[5] = '{32'hFE002E23, IMM_S,     64'h400, 64'hFFFFFFFC, 64'h3FC, 1'b0,
                   64'hFFFFFFFFFFFFFFFC, 64'h3FC, 1'b0};
        vec[6] = '{32'h02000013, IMM_SHAMT, 64'h10, 64'h0, 64'h10, 1'b1,
                   64'h20, 64'h30, 1'b0};
        vec[7] = '{32'h800FD073, IMM_CSRI,  64'hFFFFFFFFFFFFFFF0, 64'h1F, 64'hF, 1'b0,
                   64'h1F, 64'hF, 1'b0};
        vec[8] = '{32'h7FF00003, IMM_LOAD,  64'h0, 64'h7FF, 64'h7FF, 1'b0,
                   64'h7FF, 64'h7FF, 1'b0};
        vec[9] = '{32'hFE000FE3, IMM_B,     64'h1000, 64'hFFFFFFFE, 64'hFFE, 1'b0,
                   64'hFFFFFFFFFFFFFFFE, 64'hFFE, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_imm_sel = IMM_I;
        cur = '{default: '0};
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick();

        // Directed vectors, one at a time, expected values straight from the table.
        for (int k = 0; k < 10; k++) begin
            in_instr   = vec[k].instr;
            in_imm_sel = vec[k].sel;
            in_pc      = vec[k].pc;
            in_valid   = 1'b1;
            out_ready  = 1'b1;
            cur.imm32 = vec[k].imm32; cur.tgt32 = vec[k].tgt32;
            cur.pc32  = vec[k].pc & 64'hFFFF_FFFF; cur.err32 = vec[k].err32;
            cur.imm64 = vec[k].imm64; cur.tgt64 = vec[k].tgt64;
            cur.pc64  = vec[k].pc; cur.err64 = vec[k].err64;
            tick();
            in_valid = 1'b0;
            for (int w = 0; w < 6 && sb.size() > 0; w++) tick();
        end

        // Backpressure: three offers with the consumer stalled, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        offer_random(); tick();
        offer_random(); tick();
        offer_random();
        repeat (3) tick();
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (accepted) break;
        end
        in_valid = 1'b0;
        for (int w = 0; w < 8 && sb.size() > 0; w++) tick();

        // Flush with two entries in flight and a new offer in the flush cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        offer_random(); tick();
        offer_random(); tick();
        offer_random();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (4) tick();

        // Randomized traffic with random stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 99) < 3);
            out_ready = ($urandom_range(0, 99) < 70);
            in_valid  = ($urandom_range(0, 99) < 70);
            offer_random();
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 6 && sb.size() > 0; w++) tick();

        // Reset mid-stream: fill both stages, assert rst between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        offer_random(); tick();
        offer_random(); tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        edge_cnt++;
        #1;
        repeat (3) tick();

        // Pipeline still works after the mid-stream reset.
        in_instr = 32'h12345037; in_imm_sel = IMM_U; in_pc = 64'h100;
        set_model();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 6 && sb.size() > 0; w++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
